// File: rtl/dc_ipu_array_divider_pipe.sv
// Pipelined unsigned restoring array divider, STAGES_PER_REG stages per rank; DC_IPU_ARRAY_DIVIDER_REM_EN keeps the remainder.
// Latency: WIDTH/STAGES_PER_REG cycles from accept to out_valid, one op per cycle.
// Backpressure: out_valid && !out_ready freezes every rank and drops in_ready.
module dc_ipu_array_divider_pipe #(
    parameter int WIDTH          = 16,
    parameter int STAGES_PER_REG = 1,
    parameter int TAG_W          = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L = WIDTH / STAGES_PER_REG;

`ifdef DC_IPU_ARRAY_DIVIDER_REM_EN
    localparam bit KEEP_REM = 1'b1;
`else
    localparam bit KEEP_REM = 1'b0;
`endif

    if (WIDTH < 2 || (WIDTH % STAGES_PER_REG) != 0) begin : g_bad_cfg
        $error("dc_ipu_array_divider_pipe: WIDTH must be >= 2 and a multiple of STAGES_PER_REG");
    end

    // Index 0 is the live input; index k is the output of rank k.
    logic [L:0]                  vld_q;
    logic [L:0]                  dbz_q;
    logic [L:0][WIDTH-1:0]       rem_q;
    logic [L:0][WIDTH-1:0]       quo_q;
    logic [L:0][TAG_W-1:0]       tag_q;
    logic [L-1:0][WIDTH-1:0]     dvd_q;
    logic [L-1:0][WIDTH-1:0]     dsr_q;
    logic                        en;

    assign en       = !(vld_q[L] && !out_ready);
    assign in_ready = en;

    assign vld_q[0] = in_valid;
    assign dbz_q[0] = (divisor == '0);
    assign rem_q[0] = '0;
    assign quo_q[0] = '0;
    assign tag_q[0] = in_tag;
    assign dvd_q[0] = dividend;
    assign dsr_q[0] = divisor;

    for (genvar k = 0; k < L; k++) begin : g_rank
        logic [WIDTH-1:0] rem_n;
        logic [WIDTH-1:0] quo_n;
        logic [WIDTH-1:0] dvd_n;
        logic [WIDTH:0]   sh;
        logic [WIDTH:0]   diff;
        logic             vld_r;
        logic             dbz_r;
        logic [WIDTH-1:0] quo_r;
        logic [TAG_W-1:0] tag_r;

        // diff[WIDTH] is the borrow: set means the shifted remainder was below the divisor.
        always_comb begin
            rem_n = rem_q[k];
            quo_n = quo_q[k];
            dvd_n = dvd_q[k];
            sh    = '0;
            diff  = '0;
            for (int i = 0; i < STAGES_PER_REG; i++) begin
                sh    = {rem_n, dvd_n[WIDTH-1]};
                dvd_n = dvd_n << 1;
                diff  = sh - {1'b0, dsr_q[k]};
                rem_n = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
                quo_n = {quo_n[WIDTH-2:0], ~diff[WIDTH]};
            end
        end

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                vld_r <= 1'b0;
                dbz_r <= 1'b0;
                quo_r <= '0;
                tag_r <= '0;
            end else if (en) begin
                vld_r <= vld_q[k];
                dbz_r <= dbz_q[k];
                quo_r <= quo_n;
                tag_r <= tag_q[k];
            end
        end

        assign vld_q[k+1] = vld_r;
        assign dbz_q[k+1] = dbz_r;
        assign quo_q[k+1] = quo_r;
        assign tag_q[k+1] = tag_r;

        if (KEEP_REM || k < L-1) begin : g_rem
            logic [WIDTH-1:0] rem_r;
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset)
                    rem_r <= '0;
                else if (en)
                    rem_r <= rem_n;
            end
            assign rem_q[k+1] = rem_r;
        end else begin : g_no_rem
            assign rem_q[k+1] = '0;
        end

        // The last rank no longer needs the divisor or unconsumed dividend bits.
        if (k < L-1) begin : g_fwd
            logic [WIDTH-1:0] dvd_r;
            logic [WIDTH-1:0] dsr_r;
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    dvd_r <= '0;
                    dsr_r <= '0;
                end else if (en) begin
                    dvd_r <= dvd_n;
                    dsr_r <= dsr_q[k];
                end
            end
            assign dvd_q[k+1] = dvd_r;
            assign dsr_q[k+1] = dsr_r;
        end
    end

    assign out_valid   = vld_q[L];
    assign quotient    = quo_q[L];
    assign remainder   = rem_q[L];
    assign div_by_zero = dbz_q[L];
    assign out_tag     = tag_q[L];

endmodule

// File: tb/tb_dc_ipu_array_divider_pipe.sv
// Bench for dc_ipu_array_divider_pipe: 8-bit single-stage instance with a scoreboard, plus a 16-bit four-stage instance.
module tb_dc_ipu_array_divider_pipe;

    localparam int L8 = 8;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, out_valid, out_ready, div_by_zero;
    logic [7:0] dividend, divisor, quotient, remainder;
    logic [3:0] in_tag, out_tag;

    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, div_by_zero_w;
    logic [15:0] dividend_w, divisor_w, quotient_w, remainder_w;
    logic [3:0]  in_tag_w, out_tag_w;

    dc_ipu_array_divider_pipe #(.WIDTH(8), .STAGES_PER_REG(1), .TAG_W(4)) dut8 (
        .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero), .out_tag(out_tag)
    );

    dc_ipu_array_divider_pipe #(.WIDTH(16), .STAGES_PER_REG(4), .TAG_W(4)) dut16 (
        .clk(clk), .nreset(nreset), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .dividend(dividend_w), .divisor(divisor_w), .in_tag(in_tag_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .quotient(quotient_w),
        .remainder(remainder_w), .div_by_zero(div_by_zero_w), .out_tag(out_tag_w)
    );

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic [3:0] tag;
        int         issue;
        bit         chk_lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   lat_mode = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
        exp_t e;
        if (b == 8'd0) begin
            e.q   = 8'hFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
`ifndef DC_IPU_ARRAY_DIVIDER_REM_EN
        e.r = 8'd0;
`endif
        e.tag     = t;
        e.issue   = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    // Scoreboard: compare consumed results first, then record the op accepted at the coming edge.
    always @(negedge clk) begin
        if (nreset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("pending_ops_at_result", sb.size(), 1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("quotient", {24'd0, quotient}, {24'd0, mon_e.q});
                    chk("remainder", {24'd0, remainder}, {24'd0, mon_e.r});
                    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
                    chk("out_tag", {28'd0, out_tag}, {28'd0, mon_e.tag});
                    if (mon_e.chk_lat)
                        chk("latency", cyc - mon_e.issue, L8);
                end
            end
            if (in_valid && in_ready) begin
                mon_e         = model(dividend, divisor, in_tag);
                mon_e.issue   = cyc;
                mon_e.chk_lat = lat_mode;
                sb.push_back(mon_e);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
        int k;
        k = 0;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        in_tag   = t;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (!in_ready)
            chk("accept_timeout", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        #1;
        chk("drain_pending", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        in_valid = 0; dividend = 0; divisor = 0; in_tag = 0; out_ready = 1;
        in_valid_w = 0; dividend_w = 0; divisor_w = 0; in_tag_w = 0; out_ready_w = 1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_quotient", {24'd0, quotient}, 0);
        chk("rst_remainder", {24'd0, remainder}, 0);
        chk("rst_dbz", {31'd0, div_by_zero}, 0);
        chk("rst_out_tag", {28'd0, out_tag}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_valid16", {31'd0, out_valid_w}, 0);
        @(posedge clk);
        #1;

        // Single op, divide-by-zero, zero dividend, A < B
        send(8'd200, 8'd7, 4'd3);
        drain();
        send(8'd5, 8'd0, 4'd1);
        send(8'd0, 8'd9, 4'd2);
        send(8'd3, 8'd200, 4'd4);
        drain();

        // Back-to-back stream
        for (int i = 0; i < 8; i++)
            send(8'(255 - i), 8'(i + 1), 4'(i));
        drain();

        // Backpressure with a full pipe
        lat_mode = 1'b0;
        for (int i = 0; i < 10; i++)
            send(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 4'(i));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = 8'd77;
        divisor   = 8'd6;
        in_tag    = 4'd10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 0);
            chk("stall_out_valid", {31'd0, out_valid}, 1);
            chk("stall_hold_quotient", {24'd0, quotient}, {24'd0, sb[0].q});
            chk("stall_hold_tag", {28'd0, out_tag}, {28'd0, sb[0].tag});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(8'd77, 8'd6, 4'd10);
        send(8'd128, 8'd0, 4'd11);
        drain();
        lat_mode = 1'b1;

        // Reset with operations in flight
        for (int i = 0; i < 10; i++)
            send(8'(100 + i), 8'(i + 2), 4'(i));
        nreset = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 0);
        chk("midrst_quotient", {24'd0, quotient}, 0);
        chk("midrst_remainder", {24'd0, remainder}, 0);
        chk("midrst_dbz", {31'd0, div_by_zero}, 0);
        chk("midrst_out_tag", {28'd0, out_tag}, 0);
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send(8'd100, 8'd3, 4'd5);
        drain();

        // 16-bit, four stages per rank
        in_valid_w = 1'b1;
        dividend_w = 16'd50000;
        divisor_w  = 16'd123;
        in_tag_w   = 4'd9;
        @(negedge clk);
        chk("w16_in_ready", {31'd0, in_ready_w}, 1);
        @(posedge clk);
        #1;
        in_valid_w = 1'b0;
        cnt = 1;
        while (!out_valid_w && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("w16_latency", cnt, 4);
        chk("w16_quotient", {16'd0, quotient_w}, 406);
`ifdef DC_IPU_ARRAY_DIVIDER_REM_EN
        chk("w16_remainder", {16'd0, remainder_w}, 62);
`else
        chk("w16_remainder", {16'd0, remainder_w}, 0);
`endif
        chk("w16_dbz", {31'd0, div_by_zero_w}, 0);
        chk("w16_out_tag", {28'd0, out_tag_w}, 9);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dc_ipu_array_divider_pipe.md
Name: dc_ipu_array_divider_pipe

Overview:
- Fully pipelined unsigned restoring array divider for the IPU scaler datapath: computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor.
- Successor to the single-stage registered divider stage. Built from STAGES_PER_REG combinational divider stages between register ranks.
- Adds a valid/ready handshake with backpressure, a sideband tag, and divide-by-zero handling.
- Sits between the scale-factor/coordinate logic and the interpolation blocks; sustains one division per clock.

Parameters:
- WIDTH, 16, operand/quotient/remainder width in bits; must be ≥ 2.
- STAGES_PER_REG, 1, combinational restoring stages per register rank. Must divide WIDTH exactly; elaboration error otherwise.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands this cycle
- dividend  input  WIDTH  numerator A
- divisor  input  WIDTH  denominator B
- in_tag  input  TAG_W  sideband tag, returned unchanged with the result
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  A / B
- remainder  output  WIDTH  A mod B (see Optional Feature)
- div_by_zero  output  1  set when B was 0 for this result
- out_tag  output  TAG_W  tag of this result

Behaviour:
- Reset: clk and nreset; reset is asynchronous, active-low. All rank valid bits clear; all data registers 0.
  - Out of reset: out_valid=0, quotient=0, remainder=0, div_by_zero=0, out_tag=0, in_ready=1.
- Structure: L = WIDTH/STAGES_PER_REG register ranks.
  - Input passes through S stages into rank 1, S more stages into rank 2, and so on; rank L drives the outputs directly, so outputs are registered.
  - Each rank holds: valid, partial remainder (WIDTH), quotient bits resolved so far, divisor, dividend bits not yet consumed, tag, dbz flag.
- Algorithm: restoring division, MSB first.
  - Each stage shifts the next dividend bit into the partial remainder and subtracts B with WIDTH+1-bit arithmetic.
  - On no borrow: the quotient bit is 1 and the difference is kept. On borrow: the quotient bit is 0 and the old value is kept.
- Transfer: an operation is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall.
  - While stalled, all ranks hold (global enable low). Outputs stay stable until consumed.
- Bubbles: ranks advance whenever not stalled. A rank with valid=0 carries a bubble. Data registers in bubble ranks may update; outputs matter only while out_valid=1.
- Latency: with out_ready held 1, a result appears exactly L cycles after the accepting edge.
- Throughput: 1 operation per cycle. Results leave in issue order; no reordering.
- Divide by zero (B==0): quotient = all ones, remainder = dividend, div_by_zero=1. The dbz flag is captured at rank 1 and travels with the op.
- A < B: quotient=0, remainder=A.
- Extremes: A=2^WIDTH-1 with B=1 gives quotient=A, remainder=0. No overflow path exists.
- Simultaneous consume and accept while full: allowed only when out_ready=1, since in_ready then equals 1.
- Reset mid-operation: all in-flight operations are discarded with no partial output. After release, the first out_valid comes L cycles after the first new accept.

Optional Feature:
- Macro: DC_IPU_ARRAY_DIVIDER_REM_EN.
- Defined: the final partial remainder is registered through every rank and driven on remainder.
- Undefined: remainder is tied to 0. The final-rank remainder register is removed, and earlier ranks keep only what the next stage needs. quotient, div_by_zero and timing are unchanged.

Test Plan:
- WIDTH=8, S=1, out_ready=1: A=200, B=7, tag=3 -> out_valid exactly 8 cycles later with quotient=28, remainder=4, out_tag=3, div_by_zero=0.
- Zero divisor: A=5, B=0 -> quotient=0xFF, remainder=5, div_by_zero=1. Then A=0, B=9 -> quotient=0, remainder=0.
- Back-to-back: issue 8 ops on consecutive cycles (A=255..248, B=1..8) -> results on 8 consecutive cycles in issue order.
  - Values: 255/1=255 r0; 254/2=127 r0; 253/3=84 r1; 252/4=63 r0; 251/5=50 r1; 250/6=41 r4; 249/7=35 r4; 248/8=31 r0.
- Backpressure: drop out_ready for 3 cycles while the pipe is full -> in_ready=0; outputs hold the first result unchanged; no op is lost or duplicated; streaming resumes on re-assertion.
- Reset mid-flight: assert nreset low with 4 ops in flight -> out_valid=0 immediately and all outputs 0. After release, no stale result appears.
- WIDTH=16, S=4: A=50000, B=123 -> quotient=406, remainder=62, after 4 cycles.
  - Repeat with DC_IPU_ARRAY_DIVIDER_REM_EN undefined -> remainder=0, quotient unchanged.
